tdm_demux_1to16: RTL and testbench
==================================

// Module: tdm_demux_1to16
// PURPOSE
//  Receive end of the 16-channel one-bit TDM link that the 16:1 mux drives.
//  Takes the serialised bit stream plus frame marker, steps a channel counter,
//  and rebuilds the 16-bit parallel word. Channel k lands on out[k].
//  Publishes whole frames only, and flags framing loss.
// PARAMETERS
//  CH    16  channels per frame (fixed at 16 for this revision)
//  SELW  4   channel-index width, log2(CH)
// PORTS
//  clk          in   1     single clock, all state on posedge
//  rst          in   1     asynchronous, active-high reset
//  en           in   1     sample strobe; din/fsync valid only when en=1
//  din          in   1     serial data bit for the current channel
//  fsync        in   1     frame marker, high with channel 0's bit (qualified by en)
//  out          out  16    last complete frame, registered
//  sel          out  SELW  channel index expected on the next en sample
//  frame_valid  out  1     1-cycle pulse, out just updated
//  sync_err     out  1     1-cycle pulse, framing violation detected
//  locked       out  1     1 while in LOCKED state
// BEHAVIOUR
//  Reset (async, immediate): out=0, sel=0, frame_valid=0, sync_err=0,
//   locked=0, internal 16-bit shadow=0, state=HUNT. Applies mid-frame; the
//   partial frame is discarded.
//  en=0: every register holds. frame_valid/sync_err still clear after 1 cycle.
//  State HUNT (sel=0):
//   - en&fsync: shadow[0]<=din, sel<=1, go LOCKED.
//   - en&!fsync: din ignored, stay HUNT, no sync_err.
//  State LOCKED, on en:
//   - sel!=0 & !fsync: shadow[sel]<=din, sel<=sel+1 (wraps 15->0).
//   - sel==15: out<={din,shadow[14:0]}, frame_valid<=1 on the same edge, sel<=0.
//     Latency: out/frame_valid are visible 1 clk after the channel-15 sample edge.
//   - sel==0 & fsync: normal frame start, shadow[0]<=din, sel<=1.
//   - sel!=0 & fsync (early marker): sync_err<=1, partial frame dropped,
//     out unchanged, treated as new frame start: shadow[0]<=din, sel<=1.
//   - sel==0 & !fsync (missing marker): sync_err<=1, go HUNT, sel stays 0,
//     din ignored.
//  Shadow bits not yet written in the current frame are don't-care. They never
//   reach out, because out only loads on a complete 16-sample frame.
//  frame_valid and sync_err are never high in the same cycle.
//  Both pulses deassert the cycle after they assert, regardless of en.
//  locked=1 exactly while state=LOCKED.
// TESTING
//  T1 rst pulse while sel=7 in LOCKED -> out=0, sel=0, locked=0 at once, no
//     frame_valid. Next fsync-led frame 16'h0080 decodes correctly.
//  T2 en=1 each clk, fsync on ch0, frame 16'h0080 (bit7 only) -> out=16'h0080,
//     frame_valid one cycle, 1 clk after 16th sample. sync_err=0, locked=1.
//  T3 back-to-back frames 16'h8001 then 16'h2000 -> two frame_valid pulses
//     16 clks apart. out=16'h8001 then 16'h2000. out stable between pulses.
//  T4 en asserted every 3rd clk, frame 16'h0010 -> sel advances only on en.
//     out=16'h0010 after the 16th strobe. Single frame_valid.
//  T5 fsync asserted again at sel=5 -> sync_err pulse, out keeps previous
//     value, sel=1. Following 15 samples of 16'h2000 -> out=16'h2000.
//  T6 fsync missing at sel=0 -> sync_err pulse, locked=0. Next 20 en samples
//     without fsync change nothing. Next fsync relocks, frame 16'h8001 decodes.

Source files
------------

// File: rtl/tdm_demux_1to16.sv
// Receive side of the 16-channel one-bit TDM link: rebuilds parallel frames from
// the serial stream, tracks frame alignment and publishes only complete frames.
module tdm_demux_1to16 #(
  parameter int CH   = 16,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            din,
  input  logic            fsync,
  output logic [CH-1:0]   out,
  output logic [SELW-1:0] sel,
  output logic            frame_valid,
  output logic            sync_err,
  output logic            locked
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [SELW-1:0] FIRST_CH = '0;
  localparam logic [SELW-1:0] NEXT_CH  = SELW'(1);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(CH - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CH-1:0]   shadow_q, shadow_d;
  logic [CH-1:0]   out_q, out_d;
  logic            fv_q, fv_d;
  logic            se_q, se_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      sel_q    <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
    end
  end

  // Pulses default low so they last exactly one cycle whether or not en is high.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (fsync) begin
            shadow_d[0] = din;
            sel_d       = NEXT_CH;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (fsync) begin
            // A marker anywhere but channel 0 abandons the partial frame and restarts.
            se_d        = (sel_q != FIRST_CH);
            shadow_d[0] = din;
            sel_d       = NEXT_CH;
          end else if (sel_q == FIRST_CH) begin
            se_d    = 1'b1;
            state_d = HUNT;
          end else if (sel_q == LAST_CH) begin
            out_d         = shadow_q;
            out_d[CH-1]   = din;
            fv_d          = 1'b1;
            sel_d         = FIRST_CH;
          end else begin
            shadow_d[sel_q] = din;
            sel_d           = sel_q + NEXT_CH;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    out         = out_q;
    sel         = sel_q;
    frame_valid = fv_q;
    sync_err    = se_q;
    locked      = (state_q == LOCKED);
  end

endmodule

// File: tb/tb_tdm_demux_1to16.sv
// Bench for tdm_demux_1to16: directed framing scenarios plus random traffic,
// scored against a bit-queue model of the receiver.
module tb_tdm_demux_1to16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic        fsync = 1'b0;
  logic [15:0] out;
  logic [3:0]  sel;
  logic        frame_valid;
  logic        sync_err;
  logic        locked;

  tdm_demux_1to16 #(.CH(16), .SELW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .fsync(fsync),
    .out(out), .sel(sel), .frame_valid(frame_valid),
    .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit          is_frame;
    logic [15:0] val;
    int          cyc;
  } ev_t;
  ev_t sbq[$];

  // Reference model: bits collected since the last frame marker.
  bit          m_locked = 1'b0;
  bit          m_bits[$];
  logic [15:0] m_out = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_ev(input bit is_frame, input logic [15:0] v);
    ev_t e;
    e.is_frame = is_frame;
    e.val      = v;
    e.cyc      = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic model_step(input bit e, input bit d, input bit f);
    logic [15:0] v;
    if (!e) return;
    if (f) begin
      if (m_locked && m_bits.size() != 0) push_ev(1'b0, m_out);
      m_bits.delete();
      m_bits.push_back(d);
      m_locked = 1'b1;
    end else if (m_locked) begin
      if (m_bits.size() == 0) begin
        push_ev(1'b0, m_out);
        m_locked = 1'b0;
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == 16) begin
          v = '0;
          for (int i = 0; i < 16; i++) v[i] = m_bits[i];
          m_out = v;
          push_ev(1'b1, v);
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic check_state();
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("sel", {28'd0, sel}, m_locked ? m_bits.size() : 0);
    chk("out", {16'd0, out}, {16'd0, m_out});
  endtask

  task automatic sample(input bit e, input bit d, input bit f);
    @(posedge clk);
    #1;
    check_state();
    en = e; din = d; fsync = f;
    model_step(e, d, f);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    check_state();
    rst = 1'b1; en = 1'b0; fsync = 1'b0;
    #1;
    chk("rst_out", {16'd0, out}, 0);
    chk("rst_sel", {28'd0, sel}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_frame_valid", {31'd0, frame_valid}, 0);
    chk("rst_sync_err", {31'd0, sync_err}, 0);
    m_locked = 1'b0;
    m_bits.delete();
    m_out = '0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] v, input int gap);
    for (int i = 0; i < 16; i++) begin
      repeat (gap) sample(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      sample(1'b1, v[i], i == 0);
    end
  endtask

  // Monitor: every pulse must match the oldest expected event, on its cycle.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        n_chk++;
        $display("FAIL missing_pulse: no %s pulse seen, expected at cycle %0d (now %0d)",
                 e.is_frame ? "frame_valid" : "sync_err", e.cyc, cyc);
      end
      if (frame_valid || sync_err) begin
        chk("pulse_exclusive", {31'd0, frame_valid & sync_err}, 0);
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pulse: frame_valid=%0b sync_err=%0b, none expected (cycle %0d)",
                   frame_valid, sync_err, cyc);
        end else begin
          e = sbq.pop_front();
          chk("pulse_kind", {31'd0, frame_valid}, {31'd0, e.is_frame});
          chk("pulse_cycle", cyc, e.cyc);
          if (e.is_frame) chk("frame_out", {16'd0, out}, {16'd0, e.val});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int ph;
    do_reset();

    // T1: reset in the middle of a locked frame, then a clean frame.
    sample(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) sample(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    send_frame(16'h0080, 0);

    // T2/T3: back-to-back frames at full rate.
    send_frame(16'h0080, 0);
    send_frame(16'h8001, 0);
    send_frame(16'h2000, 0);

    // T4: strobe every third clock.
    send_frame(16'h0010, 2);

    // T5: early marker at channel 5, then the remainder of 16'h2000.
    for (int i = 0; i < 5; i++) sample(1'b1, 1'b1, i == 0);
    sample(1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 16; i++) sample(1'b1, (i == 13), 1'b0);

    // T6: missing marker, stray samples while hunting, relock.
    sample(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) sample(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    send_frame(16'h8001, 0);
    send_frame(16'hA5C3, 1);

    // Random traffic with occasional framing faults and resets.
    ph = 0;
    for (int n = 0; n < 3000; n++) begin
      bit e, f;
      e = ($urandom_range(0, 9) < 7);
      f = (ph == 0) ^ ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
        ph = 0;
      end
      sample(e, 1'($urandom_range(0, 1)), f);
      if (e) ph = f ? 1 : (ph + 1) % 16;
    end

    repeat (3) sample(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected pulses never seen", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
